// File: rtl/l2_insts_responder_pkg.sv
// Shared packet control-bit positions and FSM state type for the L2 instruction responder.
package l2_insts_responder_pkg;

    localparam int PKT_CTRL_BITS = 3;
    localparam int PKT_VALID_POS = 2;
    localparam int PKT_WRITE_POS = 1;
    localparam int PKT_FLAG_POS  = 0;

    // Control bits of every response: valid=1, write=0, insts flag=1.
    localparam logic [PKT_CTRL_BITS-1:0] RESP_CTRL = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HIT,
        S_MEM_REQ,
        S_MEM_WAIT,
        S_RESP
    } state_t;

endpackage

// File: rtl/l2_insts_responder_buffer.sv
// Single-entry last-block buffer: one tagged block, combinational lookup, one-cycle fill.
module l2_last_block_buffer #(
    parameter int ADDR_WIDTH = 64,
    parameter int BLOCK_BITS = 128
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic [ADDR_WIDTH-1:0] lookup_addr_in,
    output logic                  hit_out,
    output logic [BLOCK_BITS-1:0] data_out,
    input  logic                  fill_in,
    input  logic [ADDR_WIDTH-1:0] fill_tag_in,
    input  logic [BLOCK_BITS-1:0] fill_data_in
);

    logic [ADDR_WIDTH-1:0] tag_q, tag_d;
    logic [BLOCK_BITS-1:0] data_q, data_d;
    logic                  valid_q, valid_d;

    always_comb begin
        tag_d   = tag_q;
        data_d  = data_q;
        valid_d = valid_q;
        if (fill_in) begin
            tag_d   = fill_tag_in;
            data_d  = fill_data_in;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            tag_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            tag_q   <= tag_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign hit_out  = valid_q && (tag_q == lookup_addr_in);
    assign data_out = data_q;

endmodule

// File: rtl/l2_insts_responder.sv
// L2 responder for instruction fetches: serves block reads from a last-block buffer or
// from memory (BEATS return beats, beat 0 in the LSBs), answering with a one-cycle packet.
module l2_insts_responder
    import l2_insts_responder_pkg::*;
#(
    parameter int ADDR_WIDTH     = 64,
    parameter int BLOCK_BITS     = 128,
    parameter int MEM_DATA_WIDTH = 32,
    localparam int PKT_W         = ADDR_WIDTH + BLOCK_BITS + PKT_CTRL_BITS
) (
    input  logic                      clk_in,
    input  logic                      reset_in,
    input  logic [PKT_W-1:0]          l2_packet_in,
    output logic                      l2_packet_ack_out,
    output logic [PKT_W-1:0]          l2_packet_out,
    output logic                      mem_req_valid_out,
    input  logic                      mem_req_ready_in,
    output logic [ADDR_WIDTH-1:0]     mem_addr_out,
    input  logic [MEM_DATA_WIDTH-1:0] mem_data_in,
    input  logic                      mem_data_valid_in
);

    localparam int PKT_ADDR_LO = BLOCK_BITS + PKT_CTRL_BITS;
    localparam int PKT_DATA_HI = BLOCK_BITS + PKT_CTRL_BITS - 1;
    localparam int PKT_DATA_LO = PKT_CTRL_BITS;
    localparam int BEATS       = BLOCK_BITS / MEM_DATA_WIDTH;
    localparam int CNT_W       = $clog2(BEATS);
    localparam int OFFSET_BITS = $clog2(BLOCK_BITS / 8);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << OFFSET_BITS;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]   align_q, align_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [BLOCK_BITS-1:0]   block_q, block_d;
    logic                    ack_q, ack_d;
    logic [PKT_W-1:0]        pkt_q, pkt_d;
    logic                    req_valid_q, req_valid_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;

    logic [ADDR_WIDTH-1:0]   in_addr;
    logic [ADDR_WIDTH-1:0]   in_align;
    logic                    buf_hit;
    logic [BLOCK_BITS-1:0]   buf_data;
    logic                    fill_en;
    logic                    unused_pkt_bits;

    assign in_addr  = l2_packet_in[PKT_W-1:PKT_ADDR_LO];
    assign in_align = in_addr & ALIGN_MASK;
    // Request data payload and the requester's flag bit carry nothing for a read.
    assign unused_pkt_bits = ^{l2_packet_in[PKT_DATA_HI:PKT_DATA_LO], l2_packet_in[PKT_FLAG_POS]};

    l2_last_block_buffer #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .BLOCK_BITS (BLOCK_BITS)
    ) u_buffer (
        .clk_in         (clk_in),
        .reset_in       (reset_in),
        .lookup_addr_in (in_align),
        .hit_out        (buf_hit),
        .data_out       (buf_data),
        .fill_in        (fill_en),
        .fill_tag_in    (align_q),
        .fill_data_in   (block_d)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        align_d     = align_q;
        cnt_d       = cnt_q;
        block_d     = block_q;
        ack_d       = 1'b0;
        pkt_d       = '0;
        req_valid_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        fill_en     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (l2_packet_in[PKT_VALID_POS]) begin
                    ack_d = 1'b1;
                    if (!l2_packet_in[PKT_WRITE_POS]) begin
                        addr_d  = in_addr;
                        align_d = in_align;
                        if (buf_hit) begin
                            state_d = S_HIT;
                        end else begin
                            state_d     = S_MEM_REQ;
                            req_valid_d = 1'b1;
                            mem_addr_d  = in_align;
                        end
                    end
                end
            end
            // Extra cycle keeps hit latency at ack+1 so the response register lines up.
            S_HIT: begin
                state_d = S_RESP;
                pkt_d   = {addr_q, buf_data, RESP_CTRL};
            end
            S_MEM_REQ: begin
                if (mem_req_ready_in) begin
                    state_d = S_MEM_WAIT;
                end else begin
                    req_valid_d = 1'b1;
                end
            end
            S_MEM_WAIT: begin
                if (mem_data_valid_in) begin
                    block_d[cnt_q*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] = mem_data_in;
                    if (cnt_q == CNT_W'(BEATS - 1)) begin
                        cnt_d   = '0;
                        fill_en = 1'b1;
                        state_d = S_RESP;
                        pkt_d   = {addr_q, block_d, RESP_CTRL};
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            align_q     <= '0;
            cnt_q       <= '0;
            block_q     <= '0;
            ack_q       <= 1'b0;
            pkt_q       <= '0;
            req_valid_q <= 1'b0;
            mem_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            align_q     <= align_d;
            cnt_q       <= cnt_d;
            block_q     <= block_d;
            ack_q       <= ack_d;
            pkt_q       <= pkt_d;
            req_valid_q <= req_valid_d;
            mem_addr_q  <= mem_addr_d;
        end
    end

    assign l2_packet_ack_out = ack_q;
    assign l2_packet_out     = pkt_q;
    assign mem_req_valid_out = req_valid_q;
    assign mem_addr_out      = mem_addr_q;

endmodule

// File: tb/tb_l2_insts_responder.sv
// Directed bench for l2_insts_responder: transaction-level model checked every cycle,
// plus hand-computed expectations for the key scenarios.
module tb_l2_insts_responder;

    localparam int PKT_W = 195;

    logic              clk_in;
    logic              reset_in;
    logic [PKT_W-1:0]  l2_packet_in;
    logic              l2_packet_ack_out;
    logic [PKT_W-1:0]  l2_packet_out;
    logic              mem_req_valid_out;
    logic              mem_req_ready_in;
    logic [63:0]       mem_addr_out;
    logic [31:0]       mem_data_in;
    logic              mem_data_valid_in;

    l2_insts_responder dut (
        .clk_in            (clk_in),
        .reset_in          (reset_in),
        .l2_packet_in      (l2_packet_in),
        .l2_packet_ack_out (l2_packet_ack_out),
        .l2_packet_out     (l2_packet_out),
        .mem_req_valid_out (mem_req_valid_out),
        .mem_req_ready_in  (mem_req_ready_in),
        .mem_addr_out      (mem_addr_out),
        .mem_data_in       (mem_data_in),
        .mem_data_valid_in (mem_data_valid_in)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    // ---------------- behavioural model ----------------
    int               k = 0;           // rising edges seen
    int               free_at = 0;     // first edge a new request may be accepted
    int               hit_at = -1;     // edge that launches a buffered response
    bit               wait_ready = 0, collect = 0;
    int               beats = 0;
    logic [127:0]     blk;
    logic [63:0]      cur_addr, cur_align;
    bit               b_valid = 0;
    logic [63:0]      b_tag;
    logic [127:0]     b_data;
    logic             e_ack = 0, e_req = 0;
    logic [63:0]      e_addr = '0;
    logic [PKT_W-1:0] e_pkt = '0;

    initial forever begin
        logic             nack;
        logic [PKT_W-1:0] npkt;
        @(posedge clk_in or posedge reset_in);
        if (reset_in) begin
            free_at = 0; hit_at = -1; wait_ready = 0; collect = 0; beats = 0;
            b_valid = 0; e_ack = 0; e_req = 0; e_addr = '0; e_pkt = '0;
            if (clk_in) k++;
        end else begin
            k++;
            nack = 0;
            npkt = '0;
            if (wait_ready) begin
                if (mem_req_ready_in) begin
                    wait_ready = 0; collect = 1; beats = 0; e_req = 0;
                end
            end else if (collect) begin
                if (mem_data_valid_in) begin
                    blk[beats*32 +: 32] = mem_data_in;
                    beats++;
                    if (beats == 4) begin
                        collect = 0;
                        b_valid = 1; b_tag = cur_align; b_data = blk;
                        npkt = {cur_addr, blk, 3'b101};
                        free_at = k + 2;
                    end
                end
            end else if (hit_at == k) begin
                npkt = {cur_addr, b_data, 3'b101};
                hit_at = -1;
            end else if (k >= free_at && l2_packet_in[2]) begin
                nack = 1;
                if (!l2_packet_in[1]) begin
                    cur_addr  = l2_packet_in[194:131];
                    cur_align = cur_addr & ~64'hF;
                    if (b_valid && b_tag == cur_align) begin
                        hit_at = k + 1; free_at = k + 3;
                    end else begin
                        wait_ready = 1; e_req = 1; e_addr = cur_align; free_at = 1 << 30;
                    end
                end
            end
            e_ack = nack;
            e_pkt = npkt;
        end
    end

    // ---------------- per-cycle compare + observation counters ----------------
    int               resp_count = 0, ack_count = 0, req_count = 0, resp_k = -1;
    logic [PKT_W-1:0] last_resp = '0;

    initial forever begin
        @(negedge clk_in);
        check("cyc_ack", l2_packet_ack_out, e_ack);
        check("cyc_pkt", l2_packet_out, e_pkt);
        check("cyc_req_valid", mem_req_valid_out, e_req);
        if (e_req) check("cyc_mem_addr", mem_addr_out, e_addr);
        if (l2_packet_ack_out) ack_count++;
        if (mem_req_valid_out) req_count++;
        if (l2_packet_out[2]) begin
            resp_count++;
            last_resp = l2_packet_out;
            resp_k = k;
        end
    end

    // ---------------- stimulus helpers ----------------
    int          ack_k = 0, req_first_k = 0, last_beat_k = 0;
    logic [63:0] seen_addr = '0;

    task automatic send_req(input logic [63:0] a, input bit wr);
        int n;
        l2_packet_in = {a, 128'hDEADBEEF_CAFEF00D_0BADC0DE_12345678, 1'b1, wr, 1'b0};
        n = 0;
        do begin
            @(posedge clk_in); #1; n++;
        end while (!l2_packet_ack_out && n < 60);
        l2_packet_in = '0;
        if (!l2_packet_ack_out) timeout_fail("ack_wait");
        else begin
            ack_k = k;
            $display("req addr=%h write=%0d acked at edge %0d", a, wr, k);
        end
    endtask

    task automatic mem_serve(input int ready_delay, input logic [127:0] words, input int nbeats);
        int n;
        n = 0;
        while (!mem_req_valid_out && n < 50) begin
            @(posedge clk_in); #1; n++;
        end
        if (!mem_req_valid_out) begin
            timeout_fail("mem_req_wait");
            return;
        end
        seen_addr = mem_addr_out;
        req_first_k = k;
        repeat (ready_delay) begin @(posedge clk_in); #1; end
        mem_req_ready_in = 1'b1;
        @(posedge clk_in); #1;
        mem_req_ready_in = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            mem_data_valid_in = 1'b1;
            mem_data_in = words[b*32 +: 32];
            @(posedge clk_in); #1;
        end
        mem_data_valid_in = 1'b0;
        last_beat_k = k;
        $display("mem addr=%h ready_delay=%0d beats=%0d done at edge %0d", seen_addr, ready_delay, nbeats, k);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin @(posedge clk_in); #1; end
    endtask

    localparam logic [127:0] BLK1 = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] BLK2 = 128'hA0A0A0A0_B1B1B1B1_C2C2C2C2_D3D3D3D3;
    localparam logic [127:0] BLK3 = 128'h0F0F0F0F_1E1E1E1E_2D2D2D2D_3C3C3C3C;

    initial begin
        int r0, a0, q0;
        reset_in = 1'b0;
        l2_packet_in = '0;
        mem_req_ready_in = 1'b0;
        mem_data_in = '0;
        mem_data_valid_in = 1'b0;
        #2 reset_in = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        check("rst_ack", l2_packet_ack_out, 1'b0);
        check("rst_pkt", l2_packet_out, '0);
        check("rst_req", mem_req_valid_out, 1'b0);
        check("rst_addr", mem_addr_out, '0);
        reset_in = 1'b0;

        // Reset in the middle of a fill after two beats.
        send_req(64'h1004, 1'b0);
        mem_serve(0, BLK1, 2);
        reset_in = 1'b1;
        #1;
        check("midrst_ack", l2_packet_ack_out, 1'b0);
        check("midrst_pkt", l2_packet_out, '0);
        check("midrst_req", mem_req_valid_out, 1'b0);
        check("midrst_addr", mem_addr_out, '0);
        $display("reset asserted mid-fill at edge %0d", k);
        idle_cycles(2);
        reset_in = 1'b0;
        mem_data_valid_in = 1'b1;
        mem_data_in = 32'hBAD0BAD0;
        idle_cycles(2);
        mem_data_valid_in = 1'b0;

        // Read 0x1004 must miss again after reset.
        r0 = resp_count;
        send_req(64'h1004, 1'b0);
        mem_serve(0, BLK1, 4);
        @(negedge clk_in);
        check("miss_mem_addr", seen_addr, 64'h1000);
        check("miss_req_start", req_first_k, ack_k);
        check("miss_resp_edge", resp_k, last_beat_k);
        check("miss_resp_pkt", last_resp, {64'h1004, 128'h44444444_33333333_22222222_11111111, 3'b101});
        idle_cycles(2);
        check("miss_resp_once", resp_count - r0, 1);

        // Same block again: served from the buffer, no memory traffic.
        r0 = resp_count; q0 = req_count;
        send_req(64'h100C, 1'b0);
        idle_cycles(3);
        @(negedge clk_in);
        check("hit_resp_edge", resp_k, ack_k + 1);
        check("hit_resp_pkt", last_resp, {64'h100C, 128'h44444444_33333333_22222222_11111111, 3'b101});
        check("hit_no_mem_req", req_count - q0, 0);
        check("hit_resp_once", resp_count - r0, 1);

        // Memory back-pressure: request held for 5 stalled cycles plus the accepting one.
        q0 = req_count;
        send_req(64'h2000, 1'b0);
        mem_serve(5, BLK2, 4);
        idle_cycles(2);
        check("bp_req_cycles", req_count - q0, 6);
        check("bp_mem_addr", seen_addr, 64'h2000);
        check("bp_resp_pkt", last_resp, {64'h2000, 128'hA0A0A0A0_B1B1B1B1_C2C2C2C2_D3D3D3D3, 3'b101});

        // Write request: acked once, otherwise ignored; stray beats do nothing.
        r0 = resp_count; a0 = ack_count; q0 = req_count;
        send_req(64'h5000, 1'b1);
        mem_data_valid_in = 1'b1;
        mem_data_in = 32'h55555555;
        idle_cycles(3);
        mem_data_valid_in = 1'b0;
        idle_cycles(2);
        check("wr_ack_once", ack_count - a0, 1);
        check("wr_no_resp", resp_count - r0, 0);
        check("wr_no_req", req_count - q0, 0);

        // Second request held during a miss: accepted only once idle, then a buffer hit.
        r0 = resp_count; a0 = ack_count;
        send_req(64'h3000, 1'b0);
        fork
            send_req(64'h3008, 1'b0);
            mem_serve(2, BLK3, 4);
        join
        check("held_ack_after_resp", ack_k, last_beat_k + 2);
        idle_cycles(3);
        check("held_acks", ack_count - a0, 2);
        check("held_resps", resp_count - r0, 2);
        check("held_resp_pkt", last_resp, {64'h3008, 128'h0F0F0F0F_1E1E1E1E_2D2D2D2D_3C3C3C3C, 3'b101});

        idle_cycles(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
